qif_synapse: RTL and testbench
==============================

# qif_synapse

Synaptic current generator driving the QIF neuron's `I_syn` input. It accepts weighted spike events over a valid/ready handshake and buffers them in a small FIFO. Each event's weight is summed into an exponentially decaying current accumulator. The accumulator is presented as a signed 8-bit registered current directly on the neuron's synaptic input.

## Interface
- `WIDTH`, 8: bit width of weights and `I_syn`, two's complement.
- `FIFO_DEPTH`, 4: event buffer entries; power of two, at least 2.
- `DECAY_PERIOD`, 16: clock cycles between decay steps; at least 2.
- `DECAY_SHIFT`, 3: decay factor is 2^-DECAY_SHIFT per step.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `syn_en`  in  1  high enables popping events into the accumulator; decay runs regardless.
- `spk_valid`  in  1  spike event present.
- `spk_weight`  in  WIDTH  signed event weight.
- `spk_ready`  out  1  FIFO can accept an event.
- `I_syn`  out  WIDTH  signed synaptic current; registered accumulator value.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- `overflow`  out  1  sticky flag: event offered while FIFO full.

## Operation
- Reset values: `I_syn`=0, `fifo_count`=0, `spk_ready`=1, `overflow`=0. The decay counter resets to 0 and the FIFO pointers reset to 0.
- **Handshake:**
  - `spk_ready` = (`fifo_count` != FIFO_DEPTH), combinational from the registered count.
  - An event is accepted on an edge with `spk_valid`&`spk_ready`.
  - `spk_valid` may drop at any time; dropped or unaccepted events are not retried.
- **Overflow:** `overflow` is set on an edge with `spk_valid`&!`spk_ready`. It is cleared only by reset.
- **Decay counter:** free-running 0..DECAY_PERIOD-1, wrapping. The decay step fires on the edge where the count equals DECAY_PERIOD-1.
- **Per-edge action, priority order:**
  1. Decay step. Compute t = I >>> DECAY_SHIFT (arithmetic). If t==0 and I>0, t=1. Update I <= I - t. The decay step also guarantees decay to exactly 0 from either sign. No pop occurs on a decay edge.
  2. Otherwise, if `syn_en` and FIFO non-empty: pop the head entry w and update I <= I + w.
  3. Otherwise, I holds.
- **FIFO push/pop:**
  - A push and a pop may occur on the same edge; `fifo_count` is then unchanged.
  - When the FIFO is full, push is blocked even if a pop occurs on the same edge.
- **Arithmetic:** the sum is computed in WIDTH+1 bits and then reduced per Configuration.
- **Reset mid-operation:** all state clears immediately, FIFO contents are discarded, and `I_syn` goes to 0 asynchronously.

## Timing
- Event accepted at edge N is popped no earlier than edge N+1. `I_syn` reflects the popped event after edge N+1 (minimum latency 1 cycle). Each intervening decay edge delays the pop by one cycle.
- Throughput: one pop per cycle, except on decay edges.
- `I_syn` changes only on clock edges (or on reset assertion).

## Configuration
- `QIF_SYN_SAT_EN` defined: accumulation saturates, clamping to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (for WIDTH=8, [-128, 127]).
- `QIF_SYN_SAT_EN` undefined: accumulation wraps modulo 2^WIDTH.
- Decay never overflows, so decay behaviour is identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=1 mid-run with 3 FIFO entries and `I_syn`=50 → immediately `I_syn`=0, `fifo_count`=0, `spk_ready`=1, `overflow`=0; after release the decay counter restarts at 0.
- **Single event:** with `syn_en`=1, offer weight 40 on the edge at counter=2 → `I_syn`=40 after the following edge, `fifo_count` back to 0.
- **Decay sequence:** `I_syn`=40, no events → successive decay steps every 16 cycles give 35, 31, 28, 25, ...; a value of 1 decays to 0; a value of -1 decays to 0.
- **Saturation:** weights 100 then 100 → `I_syn`=127 with `QIF_SYN_SAT_EN`, -56 without. Weights -100 then -100 → -128 with the macro, 56 without.
- **Backpressure:** `syn_en`=0, `spk_valid` held for 5 cycles with weights 1..5 → 4 accepted, `spk_ready`=0 after the 4th, `overflow`=1. Raising `syn_en` → `I_syn` steps 1, 3, 6, 10 over 4 non-decay edges, and `spk_ready` returns to 1 after the first pop.
- **Decay/pop collision:** an event is pending at the edge where counter=15 → decay applied alone on that edge, and the event is added on the next edge.

Source files
------------

// File: rtl/qif_synapse.sv
// Synaptic current generator: buffers weighted spike events and accumulates them into a
// decaying signed current. Define QIF_SYN_SAT_EN for saturating accumulation (default wraps).
module qif_synapse #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned DECAY_PERIOD = 16,
   parameter int unsigned DECAY_SHIFT  = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          syn_en,
   input  logic                          spk_valid,
   input  logic [WIDTH-1:0]              spk_weight,
   output logic                          spk_ready,
   output logic [WIDTH-1:0]              I_syn,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(DECAY_PERIOD);
   localparam logic [PtrW:0]   FullCnt   = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [CntW-1:0] DecayLast = CntW'(DECAY_PERIOD - 1);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic [CntW-1:0]  dcnt_q, dcnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic push, pop, decay_fire;
   logic signed [WIDTH-1:0] acc_s, head_s, decay_t;
   logic signed [WIDTH:0]   sum;

   assign spk_ready  = (count_q != FullCnt);
   assign push       = spk_valid & spk_ready;
   assign decay_fire = (dcnt_q == DecayLast);
   assign pop        = ~decay_fire & syn_en & (count_q != '0);

   assign acc_s  = $signed(acc_q);
   assign head_s = $signed(mem_q[rd_ptr_q]);
   assign sum    = {acc_s[WIDTH-1], acc_s} + {head_s[WIDTH-1], head_s};

   always_comb begin
      decay_t = acc_s >>> DECAY_SHIFT;
      // Small positive values would stall at t=0; force a unit step so they reach zero.
      if (decay_t == '0 && !acc_s[WIDTH-1] && acc_s != '0) begin
         decay_t = {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      acc_d = acc_q;
      if (decay_fire) begin
         acc_d = acc_s - decay_t;
      end else if (pop) begin
`ifdef QIF_SYN_SAT_EN
         if (sum[WIDTH] != sum[WIDTH-1]) begin
            acc_d = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            acc_d = sum[WIDTH-1:0];
         end
`else
         acc_d = sum[WIDTH-1:0];
`endif
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      dcnt_d = decay_fire ? '0 : dcnt_q + 1'b1;
      ovf_d  = ovf_q | (spk_valid & ~spk_ready);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dcnt_q   <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dcnt_q   <= dcnt_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: entries are only read behind the registered pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= spk_weight;
      end
   end

   assign I_syn      = acc_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Scoreboard bench for qif_synapse: a queue-based reference model predicts every edge,
// plus directed checks of the key current values.
module tb_qif_synapse;

   logic       clk = 1'b0;
   logic       rst_n, syn_en, spk_valid;
   logic [7:0] spk_weight;
   logic       spk_ready;
   logic [7:0] I_syn;
   logic [2:0] fifo_count;
   logic       overflow;

   qif_synapse dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .syn_en     (syn_en),
      .spk_valid  (spk_valid),
      .spk_weight (spk_weight),
      .spk_ready  (spk_ready),
      .I_syn      (I_syn),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int i;
      int cnt;
      int rdy;
      int ovf;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_i, m_cnt;
   bit   m_ovf, m_fired;
   int   m_fifo[$];
   exp_t exp_q[$];

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int i_now();
      return int'($signed(I_syn));
   endfunction

   function automatic int reduce(input int s);
`ifdef QIF_SYN_SAT_EN
      if (s > 127) return 127;
      if (s < -128) return -128;
      return s;
`else
      if (s > 127) return s - 256;
      if (s < -128) return s + 256;
      return s;
`endif
   endfunction

   task automatic model_reset();
      m_i   = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_fifo.delete();
      exp_q.delete();
   endtask

   // Called on a falling edge; drives one cycle, predicts, then scores the result.
   task automatic step(input bit v, input int w, input bit en);
      exp_t e;
      int   t, hd;
      bit   acc;
      spk_valid  = v;
      spk_weight = w[7:0];
      syn_en     = en;
      m_fired    = (m_cnt == 15);
      acc        = v && (m_fifo.size() != 4);
      if (v && !acc) m_ovf = 1;
      if (m_fired) begin
         t = m_i >>> 3;
         if (t == 0 && m_i > 0) t = 1;
         m_i = m_i - t;
      end else if (en && m_fifo.size() != 0) begin
         hd  = m_fifo.pop_front();
         m_i = reduce(m_i + hd);
      end
      if (acc) m_fifo.push_back(w);
      m_cnt = m_fired ? 0 : m_cnt + 1;
      e.i   = m_i;
      e.cnt = m_fifo.size();
      e.rdy = (m_fifo.size() != 4) ? 1 : 0;
      e.ovf = m_ovf ? 1 : 0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_val("i_syn", i_now(), e.i);
      check_val("fifo_count", int'(fifo_count), e.cnt);
      check_val("spk_ready", int'(spk_ready), e.rdy);
      check_val("overflow", int'(overflow), e.ovf);
      @(negedge clk);
   endtask

   task automatic do_reset();
      spk_valid  = 0;
      syn_en     = 0;
      spk_weight = '0;
      rst_n      = 1;
      #1;
      check_val("rst_i_syn", i_now(), 0);
      check_val("rst_fifo_count", int'(fifo_count), 0);
      check_val("rst_spk_ready", int'(spk_ready), 1);
      check_val("rst_overflow", int'(overflow), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 0;
   endtask

   task automatic run_to_cnt(input int c, input bit en);
      while (m_cnt != c) step(0, 0, en);
   endtask

   task automatic run_to_decay(input bit en);
      do step(0, 0, en); while (!m_fired);
   endtask

   initial begin
      int dec_exp[4];
      int bp_exp[4];
      dec_exp = '{35, 31, 28, 25};
      bp_exp  = '{1, 3, 6, 10};
      rst_n      = 0;
      syn_en     = 0;
      spk_valid  = 0;
      spk_weight = '0;
      @(negedge clk);
      do_reset();

      run_to_cnt(2, 1);
      step(1, 40, 1);
      check_val("single_queued", int'(fifo_count), 1);
      step(0, 0, 1);
      check_val("single_i", i_now(), 40);
      check_val("single_drained", int'(fifo_count), 0);

      for (int k = 0; k < 4; k++) begin
         run_to_decay(1);
         check_val("decay_seq", i_now(), dec_exp[k]);
      end

      step(1, 25, 1);
      step(0, 0, 1);
      step(1, 1, 0);
      step(1, 2, 0);
      step(1, 3, 0);
      check_val("pre_rst_i", i_now(), 50);
      check_val("pre_rst_count", int'(fifo_count), 3);
      do_reset();

      step(1, 1, 1);
      step(0, 0, 1);
      check_val("pos_one", i_now(), 1);
      run_to_decay(1);
      check_val("pos_one_decay", i_now(), 0);
      step(1, -1, 1);
      step(0, 0, 1);
      check_val("neg_one", i_now(), -1);
      run_to_decay(1);
      check_val("neg_one_decay", i_now(), 0);

      do_reset();
      step(1, 100, 1);
      step(1, 100, 1);
      step(0, 0, 1);
`ifdef QIF_SYN_SAT_EN
      check_val("sum_pos", i_now(), 127);
`else
      check_val("sum_pos", i_now(), -56);
`endif
      do_reset();
      step(1, -100, 1);
      step(1, -100, 1);
      step(0, 0, 1);
`ifdef QIF_SYN_SAT_EN
      check_val("sum_neg", i_now(), -128);
`else
      check_val("sum_neg", i_now(), 56);
`endif

      do_reset();
      for (int k = 1; k <= 5; k++) begin
         step(1, k, 0);
         if (k == 4) begin
            check_val("bp_full_ready", int'(spk_ready), 0);
            check_val("bp_no_ovf_yet", int'(overflow), 0);
         end
      end
      check_val("bp_overflow", int'(overflow), 1);
      check_val("bp_count", int'(fifo_count), 4);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1);
         check_val("bp_drain_i", i_now(), bp_exp[k]);
         if (k == 0) check_val("bp_ready_back", int'(spk_ready), 1);
      end

      run_to_cnt(14, 1);
      step(1, 7, 1);
      step(0, 0, 1);
      check_val("coll_decay_only", i_now(), 9);
      check_val("coll_pending", int'(fifo_count), 1);
      step(0, 0, 1);
      check_val("coll_added", i_now(), 16);
      check_val("coll_drained", int'(fifo_count), 0);

      repeat (300) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
              $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1, "timeout");
   end

endmodule
